// File: rtl/ex_stage_md_if.sv
// ex_stage_md_if -- bundle of every non-clock signal of the execute stage.
//   master : upstream/decoder side; drives the instruction and operands,
//            receives stall and the registered results.
//   slave  : the execute stage itself.
// Signals:
//   valid_in, flush, RegDst, ALUSrc, ALUOp[2:0], MDOp[1:0],
//   forwardA[1:0], forwardB[1:0], Data1, Data2, preData, prePreData,
//   immediate, Rt, Rd                        (master -> slave)
//   stall, valid_out, Zero, ALUOut, HiOut, MemWriteData, RegDest
//                                            (slave -> master)
interface ex_stage_md_if #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
);
  logic                valid_in;
  logic                flush;
  logic                RegDst;
  logic                ALUSrc;
  logic [2:0]          ALUOp;
  logic [1:0]          MDOp;
  logic [1:0]          forwardA;
  logic [1:0]          forwardB;
  logic [WIDTH-1:0]    Data1;
  logic [WIDTH-1:0]    Data2;
  logic [WIDTH-1:0]    preData;
  logic [WIDTH-1:0]    prePreData;
  logic [WIDTH-1:0]    immediate;
  logic [REG_ADDR-1:0] Rt;
  logic [REG_ADDR-1:0] Rd;
  logic                stall;
  logic                valid_out;
  logic                Zero;
  logic [WIDTH-1:0]    ALUOut;
  logic [WIDTH-1:0]    HiOut;
  logic [WIDTH-1:0]    MemWriteData;
  logic [REG_ADDR-1:0] RegDest;

  modport master (
    output valid_in, flush, RegDst, ALUSrc, ALUOp, MDOp, forwardA, forwardB,
           Data1, Data2, preData, prePreData, immediate, Rt, Rd,
    input  stall, valid_out, Zero, ALUOut, HiOut, MemWriteData, RegDest
  );

  modport slave (
    input  valid_in, flush, RegDst, ALUSrc, ALUOp, MDOp, forwardA, forwardB,
           Data1, Data2, preData, prePreData, immediate, Rt, Rd,
    output stall, valid_out, Zero, ALUOut, HiOut, MemWriteData, RegDest
  );
endinterface

// File: rtl/ex_stage_md.sv
// ex_stage_md -- execute stage with single-cycle ALU and an iterative
// unsigned multiply/divide unit (one shift-add / restoring-subtract step
// per cycle).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ex_stage_md_if.slave (instruction, operands, forwarding,
//          stall and registered results)
// ALU ops complete one edge after presentation. MUL/DIV latch their
// operands on acceptance, run WIDTH iterations in BUSY, and deliver the
// result from DONE while the upstream instruction is finally consumed.
module ex_stage_md #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input logic          clk,
  input logic          rst,
  ex_stage_md_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mul_q, mul_d;        // 1: MUL in flight, 0: DIV
  logic [WIDTH-1:0]    b_q, b_d;            // multiplicand/divisor, also store data
  logic [WIDTH-1:0]    hi_q, hi_d;          // product high / partial remainder
  logic [WIDTH-1:0]    lo_q, lo_d;          // multiplier->product low / dividend->quotient
  logic [REG_ADDR-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]    alu_out_q, alu_out_d;
  logic [WIDTH-1:0]    hi_out_q, hi_out_d;
  logic [WIDTH-1:0]    mwd_q, mwd_d;
  logic [REG_ADDR-1:0] reg_dest_q, reg_dest_d;
  logic                valid_out_q, valid_out_d;
  logic                zero_q, zero_d;
  logic                stall_c;

  logic [WIDTH-1:0]    op_a, op_b_reg, op_b_alu, alu_res;
  logic [REG_ADDR-1:0] dest_sel;
  logic                is_md;
  logic [WIDTH:0]      mul_sum, div_shift, div_diff;
  logic                div_ge;

  // Forwarding mux: 01 two-back result, 10 one-back result, else register file.
  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] data,
                                               input logic [WIDTH-1:0] pre,
                                               input logic [WIDTH-1:0] prepre);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b01:   r = prepre;
      2'b10:   r = pre;
      default: r = data;
    endcase
    return r;
  endfunction

  // Operand selection, ALU and one multiply/divide iteration step.
  always_comb begin
    op_a     = fwd_sel(bus.forwardA, bus.Data1, bus.preData, bus.prePreData);
    op_b_reg = fwd_sel(bus.forwardB, bus.Data2, bus.preData, bus.prePreData);
    op_b_alu = bus.ALUSrc ? bus.immediate : op_b_reg;
    dest_sel = bus.RegDst ? bus.Rd : bus.Rt;
    is_md    = (bus.MDOp == 2'b01) || (bus.MDOp == 2'b10);
    case (bus.ALUOp)
      3'b000:  alu_res = op_a + op_b_alu;
      3'b001:  alu_res = op_a - op_b_alu;
      3'b010:  alu_res = op_a & op_b_alu;
      3'b011:  alu_res = op_a | op_b_alu;
      3'b100:  alu_res = op_a ^ op_b_alu;
      3'b101:  alu_res = ~(op_a | op_b_alu);
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b_alu))};
      default: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b_alu)};
    endcase
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole product right.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Restoring divide: bring in the next dividend bit and try a subtract.
    // A zero divisor always "fits", yielding all-ones quotient and the
    // dividend shifted back out as remainder.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_diff  = div_shift - {1'b0, b_q};
  end

  // Next-state, stall and output-register loads.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_d       = mul_q;
    b_d         = b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    dest_d      = dest_q;
    alu_out_d   = alu_out_q;
    hi_out_d    = hi_out_q;
    mwd_d       = mwd_q;
    reg_dest_d  = reg_dest_q;
    zero_d      = zero_q;
    valid_out_d = 1'b0;
    stall_c     = 1'b0;
    if (bus.flush) begin
      // Flush beats everything: drop any MD work, results other than valid hold.
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.valid_in && is_md) begin
            stall_c = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_LAST;
            mul_d   = (bus.MDOp == 2'b01);
            b_d     = op_b_reg;
            hi_d    = {WIDTH{1'b0}};
            lo_d    = op_a;
            dest_d  = dest_sel;
          end else if (bus.valid_in) begin
            alu_out_d   = alu_res;
            zero_d      = (alu_res == {WIDTH{1'b0}});
            hi_out_d    = {WIDTH{1'b0}};
            mwd_d       = op_b_reg;
            reg_dest_d  = dest_sel;
            valid_out_d = 1'b1;
          end else begin
            valid_out_d = 1'b0;
          end
        end
        BUSY: begin
          stall_c = 1'b1;
          if (mul_q) begin
            {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
          end else begin
            hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
          end
          if (cnt_q == {CW{1'b0}}) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          // The still-presented instruction is the one just finished; consume it.
          alu_out_d   = lo_q;
          hi_out_d    = hi_q;
          zero_d      = (lo_q == {WIDTH{1'b0}});
          reg_dest_d  = dest_q;
          mwd_d       = b_q;
          valid_out_d = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      mul_q       <= 1'b0;
      b_q         <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      lo_q        <= {WIDTH{1'b0}};
      dest_q      <= {REG_ADDR{1'b0}};
      alu_out_q   <= {WIDTH{1'b0}};
      hi_out_q    <= {WIDTH{1'b0}};
      mwd_q       <= {WIDTH{1'b0}};
      reg_dest_q  <= {REG_ADDR{1'b0}};
      valid_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_q       <= mul_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      dest_q      <= dest_d;
      alu_out_q   <= alu_out_d;
      hi_out_q    <= hi_out_d;
      mwd_q       <= mwd_d;
      reg_dest_q  <= reg_dest_d;
      valid_out_q <= valid_out_d;
      zero_q      <= zero_d;
    end
  end

  // Stall is forced low while reset is held, even with an MD op presented.
  assign bus.stall        = stall_c & rst;
  assign bus.valid_out    = valid_out_q;
  assign bus.Zero         = zero_q;
  assign bus.ALUOut       = alu_out_q;
  assign bus.HiOut        = hi_out_q;
  assign bus.MemWriteData = mwd_q;
  assign bus.RegDest      = reg_dest_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md -- randomized self-checking bench for ex_stage_md
// (WIDTH=32) against a plain-arithmetic reference model.
module tb_ex_stage_md;
  localparam int W  = 32;
  localparam int RA = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  ex_stage_md_if #(.WIDTH(W), .REG_ADDR(RA)) bus ();
  ex_stage_md #(.WIDTH(W), .REG_ADDR(RA)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference view of the registered outputs.
  logic [31:0] exp_alu, exp_hi, exp_mwd;
  logic [4:0]  exp_dest;
  logic        exp_valid, exp_zero;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.valid_out), 32'(exp_valid));
    check_eq({tag, "_aluout"}, bus.ALUOut, exp_alu);
    check_eq({tag, "_hiout"}, bus.HiOut, exp_hi);
    check_eq({tag, "_zero"}, 32'(bus.Zero), 32'(exp_zero));
    check_eq({tag, "_regdest"}, 32'(bus.RegDest), 32'(exp_dest));
    check_eq({tag, "_mwd"}, bus.MemWriteData, exp_mwd);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] d,
                                       input logic [31:0] pre, input logic [31:0] pp);
    if (sel == 2'b01) return pp;
    else if (sel == 2'b10) return pre;
    else return d;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~(a | b);
      3'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic set_instr(input logic [1:0] mdop, input logic [2:0] aluop,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic alusrc, input logic regdst,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] pre, input logic [31:0] pp,
                           input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
    bus.MDOp = mdop;  bus.ALUOp = aluop;  bus.forwardA = fa;  bus.forwardB = fb;
    bus.ALUSrc = alusrc;  bus.RegDst = regdst;
    bus.Data1 = d1;  bus.Data2 = d2;  bus.preData = pre;  bus.prePreData = pp;
    bus.immediate = imm;  bus.Rt = rt;  bus.Rd = rd;
  endtask

  // Present the instruction now on bus; flush_at = stall-cycle index at which
  // to assert flush (-1: never). Called just after a rising edge.
  task automatic run(input int flush_at);
    logic [31:0] a, br, ba, q, r;
    logic [63:0] prod;
    logic [4:0]  dst;
    int          n;
    bit          md, flushed, done;
    bus.valid_in = 1'b1;
    bus.flush    = 1'b0;
    a   = pick(bus.forwardA, bus.Data1, bus.preData, bus.prePreData);
    br  = pick(bus.forwardB, bus.Data2, bus.preData, bus.prePreData);
    ba  = bus.ALUSrc ? bus.immediate : br;
    dst = bus.RegDst ? bus.Rd : bus.Rt;
    md  = (bus.MDOp == 2'b01) || (bus.MDOp == 2'b10);
    #1;
    if (!md) begin
      check_eq("alu_stall", 32'(bus.stall), 32'd0);
      if (flush_at == 0) begin
        bus.flush = 1'b1;
        step();
        exp_valid = 1'b0;
        check_outputs("alu_flush");
        bus.flush = 1'b0;
      end else begin
        step();
        exp_alu   = alu_model(bus.ALUOp, a, ba);
        exp_zero  = (exp_alu == 32'd0);
        exp_hi    = 32'd0;
        exp_mwd   = br;
        exp_dest  = dst;
        exp_valid = 1'b1;
        check_outputs("alu");
      end
    end else begin
      if (bus.MDOp == 2'b01) begin
        prod = {32'd0, a} * {32'd0, br};
        q = prod[31:0];
        r = prod[63:32];
      end else if (br == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = a / br;
        r = a % br;
      end
      n = 0; flushed = 1'b0; done = 1'b0;
      while (!flushed && !done && n < 100) begin
        if (n == flush_at) begin
          bus.flush = 1'b1;
          #1;
          check_eq("flush_stall", 32'(bus.stall), 32'd0);
          step();
          exp_valid = 1'b0;
          check_outputs("flush");
          bus.flush    = 1'b0;
          bus.valid_in = 1'b0;
          #1;
          check_eq("post_flush_stall", 32'(bus.stall), 32'd0);
          step();
          check_outputs("post_flush");
          flushed = 1'b1;
        end else if (bus.stall !== 1'b1) begin
          done = 1'b1;
        end else begin
          n++;
          step();
          if (n == 1) check_eq("busy_valid", 32'(bus.valid_out), 32'd0);
          // Operands were latched at acceptance; disturbing them must not matter.
          bus.Data1 = $urandom;  bus.Data2 = $urandom;
          bus.preData = $urandom;  bus.prePreData = $urandom;
          bus.forwardA = 2'($urandom);  bus.forwardB = 2'($urandom);
        end
      end
      if (!flushed) begin
        check_eq("md_stall_cycles", 32'(n), 32'(W + 1));
        step();
        exp_alu   = q;
        exp_hi    = r;
        exp_zero  = (q == 32'd0);
        exp_mwd   = br;
        exp_dest  = dst;
        exp_valid = 1'b1;
        check_outputs("md");
      end
    end
  endtask

  task automatic idle_cycle();
    bus.valid_in = 1'b0;
    bus.MDOp     = 2'($urandom);
    bus.ALUOp    = 3'($urandom);
    bus.Data1    = $urandom;
    #1;
    check_eq("idle_stall", 32'(bus.stall), 32'd0);
    step();
    exp_valid = 1'b0;
    check_outputs("idle");
  endtask

  task automatic clear_exp();
    exp_alu = 32'd0; exp_hi = 32'd0; exp_mwd = 32'd0;
    exp_dest = 5'd0; exp_valid = 1'b0; exp_zero = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.valid_in = 1'b0;
    bus.flush    = 1'b0;
    set_instr(2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
    clear_exp();
    #3;
    check_outputs("por");
    check_eq("por_stall", 32'(bus.stall), 32'd0);
    #10 rst = 1'b1;
    step();

    // ADD via preData forward plus immediate, destination Rt.
    set_instr(2'd0, 3'd0, 2'b10, 2'b00, 1'b1, 1'b0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd7, 5'd3, 5'd9);
    run(-1);
    check_eq("add_const", bus.ALUOut, 32'd12);
    check_eq("add_dest", 32'(bus.RegDest), 32'd3);

    // Signed vs unsigned compare of all-ones against 1.
    set_instr(2'd0, 3'd6, 2'b00, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 5'd1, 5'd2);
    run(-1);
    check_eq("slt_const", bus.ALUOut, 32'd1);
    set_instr(2'd0, 3'd7, 2'b00, 2'b00, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1, 5'd1, 5'd2);
    run(-1);
    check_eq("sltu_const", bus.ALUOut, 32'd0);
    check_eq("sltu_zero", 32'(bus.Zero), 32'd1);

    // MUL all-ones by 2, then valid_out must drop after one cycle.
    set_instr(2'b01, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0, 5'd4, 5'd5);
    run(-1);
    check_eq("mul_lo_const", bus.ALUOut, 32'hFFFF_FFFE);
    check_eq("mul_hi_const", bus.HiOut, 32'd1);
    idle_cycle();

    // DIV 100/7 and divide by zero.
    set_instr(2'b10, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 32'd100, 32'd7, 32'd0, 32'd0, 32'd0, 5'd6, 5'd7);
    run(-1);
    check_eq("div_q_const", bus.ALUOut, 32'd14);
    check_eq("div_r_const", bus.HiOut, 32'd2);
    set_instr(2'b10, 3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 5'd6, 5'd8);
    run(-1);
    check_eq("div0_q_const", bus.ALUOut, 32'hFFFF_FFFF);
    check_eq("div0_r_const", bus.HiOut, 32'd5);

    // MUL flushed mid-iteration, then an ADD completes in one cycle.
    set_instr(2'b01, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd123, 32'd456, 32'd0, 32'd0, 32'd0, 5'd10, 5'd11);
    run(10);
    set_instr(2'd0, 3'd0, 2'b00, 2'b00, 1'b1, 1'b0, 32'd40, 32'd0, 32'd0, 32'd0, 32'd2, 5'd12, 5'd13);
    run(-1);
    check_eq("add_after_flush", bus.ALUOut, 32'd42);

    // Reset asserted mid-BUSY, then accept a new instruction on the first edge.
    set_instr(2'b01, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 32'd77, 32'd88, 32'd0, 32'd0, 32'd0, 5'd14, 5'd15);
    bus.valid_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #3;
    rst = 1'b0;
    #1;
    clear_exp();
    check_outputs("rst_busy");
    check_eq("rst_busy_stall", 32'(bus.stall), 32'd0);
    #1 rst = 1'b1;
    set_instr(2'd0, 3'd4, 2'b00, 2'b00, 1'b0, 1'b1, 32'hF0F0_0000, 32'h0F0F_1234, 32'd0, 32'd0, 32'd0, 5'd16, 5'd17);
    run(-1);

    // Random instruction stream.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) idle_cycle();
      set_instr(2'($urandom), 3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val(), 5'($urandom), 5'($urandom));
      run(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, W + 1)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
